// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory request controller.
// State encoding, response FIFO depth and its count width.
package mem_ctrl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   localparam int RSP_DEPTH = 3;
   localparam int RSP_CNT_W = $clog2(RSP_DEPTH + 1);

endpackage

// File: rtl/mem_rsp_fifo.sv
// In-order response FIFO, circular buffer, head shown on rd side.
// Ports: clk, reset, push/push_data, pop, head, count, empty.
module mem_rsp_fifo #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] buf_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // a full FIFO may still take a push when a pop frees a slot
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
   assign head    = buf_q[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            buf_q[wr_ptr] <= push_data;
            wr_ptr        <= nxt(wr_ptr);
         end
         if (do_pop)
            rd_ptr <= nxt(rd_ptr);
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/mem_req_ctrl.sv
// Valid/ready front-end for the synchronous memory, with a 3-deep
// read response FIFO and an optional fill engine.
// Ports: req_* request channel, rsp_* response channel, fill_*
// fill control, mem_* memory side. clk, sync active-high reset.
// Macro MEM_REQ_CTRL_FILL_EN enables the fill engine and FILL state.
module mem_req_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int MAX_ADDR   = 8,
   parameter int ADDRSIZE   = $clog2(MAX_ADDR)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDRSIZE-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   input  logic                  fill_start,
   input  logic [DATA_WIDTH-1:0] fill_value,
   output logic                  fill_busy,
   output logic                  mem_rd_en,
   output logic [ADDRSIZE-1:0]   mem_rd_addr,
   output logic                  mem_wr_en,
   output logic [ADDRSIZE-1:0]   mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   state_t                state;
   logic [ADDRSIZE-1:0]   fill_cnt;
   logic [DATA_WIDTH-1:0] fill_val;
   logic                  fill_block;
   logic                  inflight;
   logic [RSP_CNT_W-1:0]  fifo_count;
   logic [RSP_CNT_W:0]    outstanding;
   logic                  fifo_empty;
   logic                  room;
   logic                  accept;
   logic                  rd_acc;
   logic                  wr_acc;

   // queued plus in-flight reads must leave a slot for the new one
   assign outstanding = {1'b0, fifo_count} + (RSP_CNT_W + 1)'(inflight);
   assign room = (outstanding <= (RSP_CNT_W + 1)'(RSP_DEPTH - 1));

`ifdef MEM_REQ_CTRL_FILL_EN
   // a fill request pre-empts any request presented the same cycle
   assign fill_block = fill_start;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         fill_cnt <= '0;
         fill_val <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (fill_start) begin
                  fill_val <= fill_value;
                  fill_cnt <= '0;
                  state    <= FILL;
               end
            end
            FILL: begin
               fill_cnt <= fill_cnt + 1'b1;
               if (fill_cnt == ADDRSIZE'(MAX_ADDR - 1))
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   logic unused_fill;

   assign unused_fill = ^{fill_start, fill_value};
   assign fill_block  = 1'b0;
   assign state       = IDLE;
   assign fill_cnt    = '0;
   assign fill_val    = '0;
`endif

   assign req_ready = !reset && (state == IDLE) && !fill_block && room;
   assign accept    = req_valid && req_ready;
   assign rd_acc    = accept && !req_we;
   assign wr_acc    = accept && req_we;

   assign mem_rd_en   = rd_acc;
   assign mem_rd_addr = req_addr;
   assign mem_wr_en   = !reset && ((state == FILL) || wr_acc);
   assign mem_wr_addr = (state == FILL) ? fill_cnt : req_addr;
   assign mem_wr_data = (state == FILL) ? fill_val : req_wdata;
   assign fill_busy   = (state == FILL);

   always_ff @(posedge clk) begin
      if (reset)
         inflight <= 1'b0;
      else
         inflight <= rd_acc;
   end

   assign rsp_valid = !reset && !fifo_empty;

   mem_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (DATA_WIDTH),
      .CNT_W (RSP_CNT_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight),
      .push_data (mem_rd_data),
      .pop       (rsp_valid && rsp_ready),
      .head      (rsp_data),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl with a behavioural model of the memory.
// Table of per-cycle vectors plus fill and reset sequences.
module tb_mem_req_ctrl;

   localparam int DW = 4;
   localparam int MA = 4;
   localparam int AW = 2;
`ifdef MEM_REQ_CTRL_FILL_EN
   localparam bit FILL_ON = 1'b1;
`else
   localparam bit FILL_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          fill_start, fill_busy;
   logic [DW-1:0] fill_value;
   logic          mem_rd_en, mem_wr_en;
   logic [AW-1:0] mem_rd_addr, mem_wr_addr;
   logic [DW-1:0] mem_wr_data, mem_rd_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_req_ctrl #(.DATA_WIDTH(DW), .MAX_ADDR(MA), .ADDRSIZE(AW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .fill_start(fill_start), .fill_value(fill_value),
      .fill_busy(fill_busy),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   // memory model: registered read and write, sync reset to zero
   logic [DW-1:0] mem [MA];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MA; i++) mem[i] <= '0;
         mem_rd_data <= '0;
      end else begin
         if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
         if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
      end
   end

   typedef struct {
      logic          vld;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic          rr;
      logic          e_rdy;
      logic          e_rv;
      logic [DW-1:0] e_dat;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int v, int w, int a, int d, int r,
                               int erdy, int erv, int ed);
      vec_t t;
      t.vld = 1'(v); t.we = 1'(w); t.addr = AW'(a); t.wd = DW'(d);
      t.rr = 1'(r); t.e_rdy = 1'(erdy); t.e_rv = 1'(erv);
      t.e_dat = DW'(ed);
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic read_one(input logic [AW-1:0] a,
                           input logic [DW-1:0] e, input string nm);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = 1'b0;
      #1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk({nm, "_acc_to"}, 32'(n < 20), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk({nm, "_rsp_to"}, 32'(n < 20), 32'd1);
      chk(nm, 32'(rsp_data), 32'(e));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      int busy;
      reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; rsp_ready = 1'b0; fill_start = 1'b0;
      fill_value = '0;

      // v, we, addr, wdata, rsp_ready, exp ready, exp rsp_valid, exp data
      tbl.push_back(mk(1, 1, 3, 5, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 3, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 5));
      tbl.push_back(mk(1, 1, 0, 2, 1, 1, 0, 0));
      tbl.push_back(mk(1, 1, 1, 3, 1, 1, 0, 0));
      tbl.push_back(mk(1, 1, 2, 4, 1, 1, 0, 0));
      tbl.push_back(mk(1, 1, 3, 5, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 2, 0, 1, 1, 1, 2));
      tbl.push_back(mk(1, 0, 3, 0, 1, 1, 1, 3));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 4));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 5));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 0, 2, 0, 0, 1, 1, 2));
      tbl.push_back(mk(1, 0, 3, 0, 0, 0, 1, 2));
      tbl.push_back(mk(1, 0, 3, 0, 0, 0, 1, 2));
      tbl.push_back(mk(1, 0, 3, 0, 1, 0, 1, 2));
      tbl.push_back(mk(1, 0, 3, 0, 1, 1, 1, 3));
      tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 4));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 5));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 2));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 1, 1, 7, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 7));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));

      @(negedge clk); #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_fill_busy", 32'(fill_busy), 32'd0);
      chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_wr_en", 32'(mem_wr_en), 32'd0);

      @(negedge clk);
      reset = 1'b0; req_valid = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         req_valid = tbl[i].vld; req_we = tbl[i].we;
         req_addr = tbl[i].addr; req_wdata = tbl[i].wd;
         rsp_ready = tbl[i].rr;
         #1;
         chk($sformatf("v%0d_ready", i), 32'(req_ready),
             32'(tbl[i].e_rdy));
         chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid),
             32'(tbl[i].e_rv));
         if (tbl[i].e_rv)
            chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data),
                32'(tbl[i].e_dat));
      end

      // fill: memory now holds 2,7,4,5
      @(negedge clk);
      req_valid = 1'b0; rsp_ready = 1'b1;
      fill_start = 1'b1; fill_value = 4'd6;
      #1;
      chk("fill_start_ready", 32'(req_ready), 32'(!FILL_ON));
      busy = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         fill_start = 1'b0;
         #1;
         if (k == 0)
            chk("fill_busy_first", 32'(fill_busy), 32'(FILL_ON));
         if (fill_busy) begin
            chk($sformatf("fill%0d_ready", busy), 32'(req_ready), 32'd0);
            chk($sformatf("fill%0d_wr_en", busy), 32'(mem_wr_en), 32'd1);
            chk($sformatf("fill%0d_wr_addr", busy), 32'(mem_wr_addr),
                32'(busy));
            chk($sformatf("fill%0d_wr_data", busy), 32'(mem_wr_data),
                32'd6);
            busy++;
         end
      end
      chk("fill_cycles", 32'(busy), FILL_ON ? 32'(MA) : 32'd0);
      rsp_ready = 1'b0;

      read_one(2'd0, FILL_ON ? 4'd6 : 4'd2, "post_fill_a0");
      read_one(2'd1, FILL_ON ? 4'd6 : 4'd7, "post_fill_a1");
      read_one(2'd2, FILL_ON ? 4'd6 : 4'd4, "post_fill_a2");
      read_one(2'd3, FILL_ON ? 4'd6 : 4'd5, "post_fill_a3");

      // reset with two responses queued
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd2; rsp_ready = 1'b0;
      #1 chk("mid_acc0", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_addr = 2'd3;
      #1 chk("mid_acc1", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk); #1;
      chk("mid_queued_valid", 32'(rsp_valid), 32'd1);
      chk("mid_queued_data", 32'(rsp_data), FILL_ON ? 32'd6 : 32'd4);
      reset = 1'b1;
      #1 chk("mid_rst_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      read_one(2'd2, 4'd0, "post_rst_a2");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
